// File: rtl/cycle_bcd_converter_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package cycle_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_e;

  localparam int BIN_W       = 32;
  localparam int SCR_DIGITS  = 10;
  localparam int OUT_DIGITS  = 8;
  localparam int SHIFT_COUNT = 32;

  localparam logic [31:0] SAT_BCD = 32'h99999999;

endpackage

// File: rtl/cycle_bcd_converter_if.sv
// Conversion request/result bundle between the cycle counter path and the display driver.
interface cycle_bcd_converter_if;
  import cycle_bcd_pkg::*;

  logic [BIN_W-1:0]        bin;
  logic                    start;
  logic [4*OUT_DIGITS-1:0] bcd;
  logic [OUT_DIGITS-1:0]   digit_en;
  logic                    overflow;
  logic                    busy;
  logic                    done;

  modport master (
    output bin, start,
    input  bcd, digit_en, overflow, busy, done
  );

  modport slave (
    input  bin, start,
    output bcd, digit_en, overflow, busy, done
  );

endinterface

// File: rtl/cycle_bcd_converter_digit_adj.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Inputs above 9 never occur, so the 4-bit sum cannot wrap.
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/cycle_bcd_converter.sv
// Sequential double-dabble converter: one shift per clock, result held stable between conversions.
module cycle_bcd_converter
  import cycle_bcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 0,
  parameter int DIGITS         = 8
) (
  input logic                  clk,
  input logic                  resetn,
  cycle_bcd_converter_if.slave bus
);

  localparam logic        REFRESH_EN   = (REFRESH_CYCLES != 0);
  localparam logic [31:0] REFRESH_LAST = REFRESH_EN ? 32'(REFRESH_CYCLES - 1) : 32'd0;
  localparam int          SCR_W        = 4 * SCR_DIGITS;

  state_e                  state_q, state_d;
  logic [BIN_W-1:0]        shreg_q, shreg_d;
  logic [SCR_W-1:0]        scratch_q, scratch_d, scratch_adj;
  logic [5:0]              count_q, count_d;
  logic [31:0]             refresh_q, refresh_d;
  logic [4*OUT_DIGITS-1:0] bcd_q, bcd_d;
  logic [OUT_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    overflow_q, overflow_d;
  logic                    done_q, done_d;
  logic                    trigger;
  logic [SCR_W+BIN_W-1:0]  shifted;
  logic                    unused_adj_msb;
  int                      msd;

  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (scratch_q[4*g +: 4]),
      .nib_o (scratch_adj[4*g +: 4])
    );
  end

  // The top scratch digit can never reach 5, so its adjusted value never carries out.
  assign shifted        = {scratch_adj[SCR_W-2:0], shreg_q, 1'b0};
  assign unused_adj_msb = scratch_adj[SCR_W-1];
  assign trigger        = bus.start || (REFRESH_EN && (refresh_q == REFRESH_LAST));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      refresh_q  <= '0;
      bcd_q      <= '0;
      digit_en_q <= 8'h01;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      refresh_q  <= refresh_d;
      bcd_q      <= bcd_d;
      digit_en_q <= digit_en_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    refresh_d  = refresh_q;
    bcd_d      = bcd_q;
    digit_en_d = digit_en_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    msd        = 0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          shreg_d   = bus.bin;
          scratch_d = '0;
          count_d   = '0;
          refresh_d = '0;
          state_d   = SHIFT;
        end else if (REFRESH_EN && !done_q) begin
          // The cycle showing done still belongs to the conversion, not the idle gap.
          refresh_d = refresh_q + 32'd1;
        end
      end
      SHIFT: begin
        scratch_d = shifted[SCR_W+BIN_W-1:BIN_W];
        shreg_d   = shifted[BIN_W-1:0];
        count_d   = count_q + 6'd1;
        if (count_q == 6'(SHIFT_COUNT - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        overflow_d = |scratch_q[SCR_W-1:4*OUT_DIGITS];
        bcd_d      = overflow_d ? SAT_BCD : scratch_q[4*OUT_DIGITS-1:0];
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_d[4*i +: 4] != 4'd0) begin
            msd = i;
          end
        end
        for (int j = 0; j < OUT_DIGITS; j++) begin
          digit_en_d[j] = (j <= msd);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.bcd      = bcd_q;
    bus.digit_en = digit_en_q;
    bus.overflow = overflow_q;
    bus.busy     = (state_q != IDLE);
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_cycle_bcd_converter.sv
// Scoreboard bench: a decimal reference model feeds expected results to a done-driven monitor.
module tb_cycle_bcd_converter;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  digitEn;
    logic        overflow;
  } expect_t;

  logic clk;
  logic resetn;
  logic resetn2;
  int   checks    = 0;
  int   errors    = 0;
  int   doneCount = 0;
  int   refDones  = 0;
  int   cyc       = 0;
  int   lastDone  = -1;
  expect_t expQ[$];

  cycle_bcd_converter_if bus ();
  cycle_bcd_converter_if bus2 ();

  cycle_bcd_converter #(.REFRESH_CYCLES(0), .DIGITS(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  cycle_bcd_converter #(.REFRESH_CYCLES(100), .DIGITS(8)) dutRefresh (
    .clk    (clk),
    .resetn (resetn2),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference model works on decimal digits directly rather than on shifts.
  function automatic expect_t refModel(input logic [31:0] v);
    expect_t e;
    longint val = longint'(v);
    longint p   = 1;
    if (val > 99999999) begin
      e.bcd      = 32'h99999999;
      e.digitEn  = 8'hFF;
      e.overflow = 1'b1;
    end else begin
      e.overflow = 1'b0;
      for (int i = 0; i < 8; i++) begin
        e.bcd[4*i +: 4] = 4'((val / p) % 10);
        e.digitEn[i]    = (i == 0) || (val >= p);
        p = p * 10;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    int guard = 0;
    int lat   = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idle_before_start", bus.busy, 0);
    bus.bin   = v;
    bus.start = 1'b1;
    expQ.push_back(refModel(v));
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("done_latency", lat, 33);
  endtask

  task automatic ignoreStartTest();
    int startDone = doneCount;
    int lat       = 0;
    bit busyDrop  = 1'b0;
    bus.bin   = 42;
    bus.start = 1'b1;
    expQ.push_back(refModel(42));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (!bus.busy) busyDrop = 1'b1;
    end
    bus.bin   = 7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busyDrop = 1'b1;
      @(negedge clk);
      lat++;
    end
    checkOutput("busy_continuous", 32'(busyDrop), 0);
    repeat (40) @(negedge clk);
    checkOutput("ignored_start_dones", doneCount - startDone, 1);
  endtask

  task automatic resetMidTest();
    int startDone = doneCount;
    bus.bin   = 87654321;
    bus.start = 1'b1;
    expQ.push_back(refModel(87654321));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    resetn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("reset_bcd", bus.bcd, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_digit_en", bus.digit_en, 8'h01);
    checkOutput("reset_overflow", bus.overflow, 0);
    checkOutput("reset_done", bus.done, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("reset_no_done", doneCount - startDone, 0);
    checkOutput("reset_bcd_held", bus.bcd, 0);
    applyStimulus(5);
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.done) begin
        doneCount++;
        checkOutput("done_busy_low", bus.busy, 0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no pending conversion");
        end else begin
          e = expQ.pop_front();
          checkOutput("bcd", bus.bcd, e.bcd);
          checkOutput("digit_en", bus.digit_en, 32'(e.digitEn));
          checkOutput("overflow", bus.overflow, 32'(e.overflow));
        end
      end
    end
  end

  initial begin : refreshMonitor
    expect_t e;
    e = refModel(2024);
    forever begin
      @(negedge clk);
      if (resetn2 && bus2.done) begin
        if (lastDone >= 0) checkOutput("refresh_period", cyc - lastDone, 134);
        lastDone = cyc;
        refDones++;
        checkOutput("refresh_bcd", bus2.bcd, e.bcd);
        checkOutput("refresh_digit_en", bus2.digit_en, 32'(e.digitEn));
        checkOutput("refresh_overflow", bus2.overflow, 32'(e.overflow));
      end else if (refDones > 0) begin
        checkOutput("refresh_hold", bus2.bcd, e.bcd);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] v;
    int guard = 0;
    resetn    = 1'b0;
    resetn2   = 1'b0;
    bus.bin   = '0;
    bus.start = 1'b0;
    bus2.bin  = 2024;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    resetn  = 1'b1;
    resetn2 = 1'b1;
    @(negedge clk);
    checkOutput("init_bcd", bus.bcd, 0);
    checkOutput("init_digit_en", bus.digit_en, 8'h01);
    checkOutput("init_overflow", bus.overflow, 0);
    checkOutput("init_busy", bus.busy, 0);
    checkOutput("init_done", bus.done, 0);

    applyStimulus(0);
    applyStimulus(12345678);
    applyStimulus(305);
    applyStimulus(99999999);
    applyStimulus(100000000);
    applyStimulus(32'hFFFFFFFF);
    ignoreStartTest();
    resetMidTest();

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(99999990, 100000010);
      endcase
      applyStimulus(v);
    end

    repeat (5) @(negedge clk);
    while (refDones < 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("refresh_done_seen", 32'(refDones >= 3), 1);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
